ex2mem_skid_reg: RTL and testbench

Parametrised EX->MEM pipeline stage with an elastic valid/ready handshake and a 2-entry skid buffer (main + skid), replacing the enable-only stage register. The MEM stage can stall without combinationally back-propagating ready into EX. Supports a synchronous flush for branch/trap squash, and exports forwarding info for the hazard unit. Sits between the ALU/branch unit and the load/store/CSR stage.

---
 rtl/ex2mem_skid_reg.sv | 217 +++++++++++++++++++++
 tb/tb_ex2mem_skid_reg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex2mem_skid_reg.sv
// ---------------------------------------------------------------------------
// ex2mem_skid_reg
//
// EX->MEM pipeline stage with an elastic valid/ready handshake. It holds up
// to two instructions: a main entry that is presented to MEM, and a skid
// entry that catches the instruction EX launched in the same cycle that MEM
// stalled. Because of the skid entry, in_ready is a plain register and never
// depends combinationally on out_ready. This keeps the MEM stall path out of
// the EX timing path.
//
// A synchronous flush squashes both held entries, for branch or trap
// recovery. Forwarding information for the main entry goes to the hazard unit.
//
// Parameters
//   W  datapath width (result, store data, pc+4)
//   R  register-index width
//   C  CSR address width
//   F  funct3 width
//   O  compressed opcode width
//
// Ports
//   clk1, a_reset_n        stage clock (rising edge), async active-low reset
//   flush                  synchronous squash of all held entries
//   in_valid / in_ready    upstream handshake (in_ready is registered)
//   in_*                   instruction payload from EX
//   out_valid / out_ready  downstream handshake (out_valid = main entry held)
//   out_*                  main-entry payload; out_useRd/out_useCsr gated by valid
//   fwd_valid/rd/result    forwarding view of the main entry (rd x0 suppressed)
//   occupancy              number of held entries, 0..2
// ---------------------------------------------------------------------------
module ex2mem_skid_reg #(
    parameter int W = 32,
    parameter int R = 5,
    parameter int C = 3,
    parameter int F = 3,
    parameter int O = 2
) (
    input  logic         clk1,
    input  logic         a_reset_n,
    input  logic         flush,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_result,
    input  logic [W-1:0] in_data,
    input  logic [R-1:0] in_rd,
    input  logic [C-1:0] in_csr_addr,
    input  logic [F-1:0] in_funct3,
    input  logic [O-1:0] in_opcode,
    input  logic         in_useRd,
    input  logic         in_useCsr,
    input  logic [W-1:0] in_jmp_pc4,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [W-1:0] out_data,
    output logic [R-1:0] out_rd,
    output logic [C-1:0] out_csr_addr,
    output logic [F-1:0] out_funct3,
    output logic [O-1:0] out_opcode,
    output logic         out_useRd,
    output logic         out_useCsr,
    output logic [W-1:0] out_jmp_pc4,

    output logic         fwd_valid,
    output logic [R-1:0] fwd_rd,
    output logic [W-1:0] fwd_result,

    output logic [1:0]   occupancy
);

    // One held instruction. The main and skid entries share this layout,
    // so the skid entry can move into the main entry as a single copy.
    typedef struct packed {
        logic [W-1:0] result;
        logic [W-1:0] data;
        logic [R-1:0] rd;
        logic [C-1:0] csr_addr;
        logic [F-1:0] funct3;
        logic [O-1:0] opcode;
        logic         use_rd;
        logic         use_csr;
        logic [W-1:0] jmp_pc4;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t   state_q,      state_d;
    payload_t main_q,       main_d;
    payload_t skid_q,       skid_d;
    logic     main_valid_q, main_valid_d;
    logic     in_ready_q,   in_ready_d;
    logic [1:0] occupancy_q, occupancy_d;

    payload_t in_payload;
    logic     accept;
    logic     consume;

    always_comb begin
        in_payload.result   = in_result;
        in_payload.data     = in_data;
        in_payload.rd       = in_rd;
        in_payload.csr_addr = in_csr_addr;
        in_payload.funct3   = in_funct3;
        in_payload.opcode   = in_opcode;
        in_payload.use_rd   = in_useRd;
        in_payload.use_csr  = in_useCsr;
        in_payload.jmp_pc4  = in_jmp_pc4;
    end

    // The handshakes use only registered ready/valid, so neither handshake
    // forms a combinational path through this stage.
    assign accept  = in_valid & in_ready_q;
    assign consume = main_valid_q & out_ready;

    // Next-state logic. Payload registers load only when an entry is
    // written. A flush or a drain leaves stale data in them. Consumers
    // never see that stale data because the side-band outputs are gated
    // by valid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Squash wins over every handshake. An instruction that EX
            // offers in this cycle is dropped as well.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_payload;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = in_payload;
                    end else if (accept) begin
                        // MEM stalled while EX launched. Park the newcomer
                        // behind the main entry.
                        skid_d  = in_payload;
                        state_d = ST_FULL;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        main_valid_d = (state_d != ST_EMPTY);
        in_ready_d   = (state_d != ST_FULL);

        case (state_d)
            ST_ONE:  occupancy_d = 2'd1;
            ST_FULL: occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk1 or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q      <= ST_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            occupancy_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            in_ready_q   <= in_ready_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign occupancy    = occupancy_q;

    assign out_valid    = main_valid_q;
    assign out_result   = main_q.result;
    assign out_data     = main_q.data;
    assign out_rd       = main_q.rd;
    assign out_csr_addr = main_q.csr_addr;
    assign out_funct3   = main_q.funct3;
    assign out_opcode   = main_q.opcode;
    assign out_jmp_pc4  = main_q.jmp_pc4;

    // Gate the side-band enables with valid, so stale payload left after a
    // flush or drain cannot trigger a write or a forward.
    assign out_useRd    = main_q.use_rd  & main_valid_q;
    assign out_useCsr   = main_q.use_csr & main_valid_q;

    // x0 is hard-wired zero, so forwarding it would be wrong.
    assign fwd_valid    = main_valid_q & main_q.use_rd & (main_q.rd != '0);
    assign fwd_rd       = main_q.rd;
    assign fwd_result   = main_q.result;

endmodule

// File: tb/tb_ex2mem_skid_reg.sv
module tb_ex2mem_skid_reg;

    localparam int W = 32;
    localparam int R = 5;
    localparam int C = 3;
    localparam int F = 3;
    localparam int O = 2;

    typedef struct {
        logic [W-1:0] result;
        logic [W-1:0] data;
        logic [R-1:0] rd;
        logic [C-1:0] csr_addr;
        logic [F-1:0] funct3;
        logic [O-1:0] opcode;
        logic         use_rd;
        logic         use_csr;
        logic [W-1:0] jmp_pc4;
    } txn_t;

    logic         clk1;
    logic         a_reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [W-1:0] out_data;
    logic [R-1:0] out_rd;
    logic [C-1:0] out_csr_addr;
    logic [F-1:0] out_funct3;
    logic [O-1:0] out_opcode;
    logic         out_useRd;
    logic         out_useCsr;
    logic [W-1:0] out_jmp_pc4;
    logic         fwd_valid;
    logic [R-1:0] fwd_rd;
    logic [W-1:0] fwd_result;
    logic [1:0]   occupancy;

    txn_t drive_txn;

    txn_t exp_q[$];
    int   checks;
    int   errors;
    bit   mon_en;

    ex2mem_skid_reg #(.W(W), .R(R), .C(C), .F(F), .O(O)) dut (
        .clk1        (clk1),
        .a_reset_n   (a_reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (drive_txn.result),
        .in_data     (drive_txn.data),
        .in_rd       (drive_txn.rd),
        .in_csr_addr (drive_txn.csr_addr),
        .in_funct3   (drive_txn.funct3),
        .in_opcode   (drive_txn.opcode),
        .in_useRd    (drive_txn.use_rd),
        .in_useCsr   (drive_txn.use_csr),
        .in_jmp_pc4  (drive_txn.jmp_pc4),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_csr_addr(out_csr_addr),
        .out_funct3  (out_funct3),
        .out_opcode  (out_opcode),
        .out_useRd   (out_useRd),
        .out_useCsr  (out_useCsr),
        .out_jmp_pc4 (out_jmp_pc4),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_result  (fwd_result),
        .occupancy   (occupancy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.result   = $urandom;
        t.data     = $urandom;
        t.rd       = R'($urandom_range(0, 31));
        t.csr_addr = C'($urandom_range(0, 7));
        t.funct3   = F'($urandom_range(0, 7));
        t.opcode   = O'($urandom_range(0, 3));
        t.use_rd   = 1'($urandom_range(0, 1));
        t.use_csr  = 1'($urandom_range(0, 1));
        t.jmp_pc4  = $urandom;
        return t;
    endfunction

    // Reference model: the stage is a FIFO of capacity two. EX may push when
    // fewer than two entries are held, and MEM pops the head when ready. A
    // flush or reset empties it.
    always @(posedge clk1 or negedge a_reset_n) begin
        bit acc;
        bit con;
        if (!a_reset_n) begin
            exp_q.delete();
        end else begin
            acc = in_valid && (exp_q.size() < 2);
            con = out_ready && (exp_q.size() > 0);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (con) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(drive_txn);
            end
        end
    end

    // Monitor: compares the DUT view against the head of the model FIFO.
    task automatic checkOutput();
        int   n;
        txn_t e;
        n = exp_q.size();
        compareVal("out_valid", 32'(out_valid), 32'(n > 0));
        compareVal("in_ready",  32'(in_ready),  32'(n < 2));
        compareVal("occupancy", 32'(occupancy), 32'(n));
        if (n > 0) begin
            e = exp_q[0];
            compareVal("out_result",   out_result,          e.result);
            compareVal("out_data",     out_data,            e.data);
            compareVal("out_rd",       32'(out_rd),         32'(e.rd));
            compareVal("out_csr_addr", 32'(out_csr_addr),   32'(e.csr_addr));
            compareVal("out_funct3",   32'(out_funct3),     32'(e.funct3));
            compareVal("out_opcode",   32'(out_opcode),     32'(e.opcode));
            compareVal("out_jmp_pc4",  out_jmp_pc4,         e.jmp_pc4);
            compareVal("out_useRd",    32'(out_useRd),      32'(e.use_rd));
            compareVal("out_useCsr",   32'(out_useCsr),     32'(e.use_csr));
            compareVal("fwd_valid",    32'(fwd_valid),      32'(e.use_rd && (e.rd != 0)));
            compareVal("fwd_rd",       32'(fwd_rd),         32'(e.rd));
            compareVal("fwd_result",   fwd_result,          e.result);
        end else begin
            compareVal("out_useRd_idle",  32'(out_useRd),  32'd0);
            compareVal("out_useCsr_idle", 32'(out_useCsr), 32'd0);
            compareVal("fwd_valid_idle",  32'(fwd_valid),  32'd0);
        end
    endtask

    always @(negedge clk1) begin
        if (a_reset_n && mon_en) checkOutput();
    end

    // Drives one cycle of inputs just after a rising edge and holds them
    // through the next rising edge.
    task automatic applyStimulus(input bit v, input bit ordy, input bit fl, input txn_t t);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        drive_txn = t;
        @(posedge clk1);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges. The clear must
    // show up at once, without waiting for a clock edge.
    task automatic pulse_reset();
        #1 a_reset_n = 1'b0;
        #1;
        compareVal("async_rst_out_valid",  32'(out_valid),  32'd0);
        compareVal("async_rst_out_result", out_result,      32'd0);
        compareVal("async_rst_in_ready",   32'(in_ready),   32'd1);
        compareVal("async_rst_occupancy",  32'(occupancy),  32'd0);
        a_reset_n = 1'b1;
        @(posedge clk1);
        #1;
    endtask

    txn_t idle;
    txn_t t;

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        a_reset_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        idle      = '{default: '0};
        drive_txn = idle;

        #11;
        compareVal("reset_out_valid",  32'(out_valid),  32'd0);
        compareVal("reset_in_ready",   32'(in_ready),   32'd1);
        compareVal("reset_occupancy",  32'(occupancy),  32'd0);
        compareVal("reset_out_result", out_result,      32'd0);
        compareVal("reset_fwd_valid",  32'(fwd_valid),  32'd0);
        #1 a_reset_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk1);
        #1;

        // Single instruction, first-result latency.
        t = rand_txn();
        t.result = 32'h0000_1234;
        t.rd     = 5'd5;
        t.use_rd = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Back-to-back stream with MEM always ready.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, rand_txn());
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Fill main and skid while stalled, then drain.
        applyStimulus(1'b1, 1'b0, 1'b0, rand_txn());
        applyStimulus(1'b1, 1'b0, 1'b0, rand_txn());
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Flush while full, with a competing instruction offered.
        applyStimulus(1'b1, 1'b0, 1'b0, rand_txn());
        applyStimulus(1'b1, 1'b0, 1'b0, rand_txn());
        applyStimulus(1'b1, 1'b0, 1'b1, rand_txn());
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Writes to x0 must not be forwarded.
        t = rand_txn();
        t.rd     = '0;
        t.use_rd = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Asynchronous reset while full.
        applyStimulus(1'b1, 1'b0, 1'b0, rand_txn());
        applyStimulus(1'b1, 1'b0, 1'b0, rand_txn());
        in_valid = 1'b0;
        pulse_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 31) == 0,
                          rand_txn());
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, idle);

        @(negedge clk1);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
